complex_integer_divider_unit: RTL and testbench
===============================================

Name: complex_integer_divider_unit

Overview:
- Iterative radix-2 integer divider owned by the complex-integer execution stage, directly downstream of complex-integer register read.
- Implements the divider reservation protocol: the issue queue reserves the unit when it issues a div; register read cancels the reservation when the div is flushed there (isFlushed); execute starts the division.
- Holds the result until writeback acknowledges it, so at most one div is in flight.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- TAG_WIDTH, 7, active-list pointer width carried with the op.
- PREG_WIDTH, 7, physical destination register number width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- reserve  in  1  issue queue issued a div this cycle.
- cancel  in  1  register read flushed the reserved div (isFlushed).
- start  in  1  valid div entering execute; operands valid.
- op  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU.
- dividend  in  DATA_WIDTH  operand A.
- divisor  in  DATA_WIDTH  operand B.
- tag_in  in  TAG_WIDTH  active-list pointer of the op.
- dst_in  in  PREG_WIDTH  physical destination register.
- flush_inflight  in  1  recovery kills the op held in the unit.
- result_ack  in  1  writeback consumed the result.
- is_free  out  1  unit can accept reserve; gates div issue.
- result_valid  out  1  result available.
- result  out  DATA_WIDTH  quotient or remainder.
- tag_out  out  TAG_WIDTH  tag of the result.
- dst_out  out  PREG_WIDTH  destination of the result.

Behaviour:
- States: FREE, RESERVED, BUSY, DONE. Reset (rst=0, async): FREE, is_free=1, result_valid=0, counter=0, result/tag_out/dst_out=0.
- FREE:
  - reserve -> RESERVED.
  - start/cancel/flush_inflight ignored.
- RESERVED:
  - cancel or flush_inflight -> FREE; these take priority over start.
  - start -> latch op, tag, dst and operand magnitudes. Signed ops use absolute values; latch quotient/remainder sign flags.
  - On start, a special case goes straight to DONE; otherwise -> BUSY with counter=DATA_WIDTH-1.
  - reserve ignored.
- BUSY:
  - One restoring-division step per cycle: shift the partial remainder left by 1 and bring in the next dividend MSB; subtract the divisor magnitude if it fits; shift the quotient bit in.
  - counter==0 at the clock edge -> DONE; otherwise decrement.
  - flush_inflight -> FREE; iteration abandoned.
- DONE:
  - result_valid=1; result, tag_out, dst_out stable until leaving DONE.
  - result_ack -> FREE, or -> RESERVED if reserve is high the same cycle (back-to-back divs).
  - flush_inflight -> FREE and has priority over result_ack. result_valid drops the next cycle.
- is_free = (state==FREE) || (state==DONE && result_ack && !flush_inflight).
  - A reserve seen while is_free=0 is an issue-queue protocol violation.
  - The RTL carries a simulation-only assertion for it; hardware ignores it.
- Latency: start at edge E -> result_valid high after edge E+DATA_WIDTH (32 cycles). Special cases: result_valid high after edge E.
- Sign fix: DIV negates the quotient when the operand signs differ; REM gives the remainder the dividend's sign. Applied combinationally in DONE from the latched flags.
- Special cases (RISC-V semantics), all 1-cycle:
  - divisor==0: DIV/DIVU result = all ones; REM/REMU result = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): DIV result = most-negative; REM result = 0.
- Magnitudes use DATA_WIDTH bits unsigned; the partial remainder uses DATA_WIDTH+1 bits so the subtraction cannot overflow.
- No stall input: the unit keeps iterating under backend stall, and writeback withholds result_ack while stalled.

Test Plan:
- DIVU 100/7: reserve, start next cycle -> result_valid exactly 32 cycles after start, result=14, tag/dst echoed. REMU of same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> 0x80000000 after 1 cycle; REM of same -> 0.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF after 1 cycle; REM 5/0 -> 5.
- Reserve then cancel with start=1 same cycle -> FREE, is_free=1 next cycle, no result_valid ever.
- flush_inflight at iteration 10 of BUSY -> FREE next cycle, is_free=1. Then flush_inflight and result_ack together in DONE -> FREE, result_valid=0 next cycle.
- DONE with result_ack and reserve same cycle -> RESERVED. Second start completes 32 cycles later. Async rst=0 mid-BUSY -> all outputs 0 and is_free=1 immediately, without a clock edge.

Source files
------------

// File: rtl/complex_integer_divider_unit_if.sv
// Handshake and data bundle between the complex-integer pipeline and the divider.
// master: issue queue / register read / execute / writeback side. slave: the divider.
interface complex_integer_divider_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 7,
  parameter int unsigned PREG_WIDTH = 7
);
  logic                  reserve;
  logic                  cancel;
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic [PREG_WIDTH-1:0] dst_in;
  logic                  flush_inflight;
  logic                  result_ack;
  logic                  is_free;
  logic                  result_valid;
  logic [DATA_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]  tag_out;
  logic [PREG_WIDTH-1:0] dst_out;

  modport master (
    output reserve, cancel, start, op, dividend, divisor, tag_in, dst_in,
    output flush_inflight, result_ack,
    input  is_free, result_valid, result, tag_out, dst_out
  );

  modport slave (
    input  reserve, cancel, start, op, dividend, divisor, tag_in, dst_in,
    input  flush_inflight, result_ack,
    output is_free, result_valid, result, tag_out, dst_out
  );
endinterface

// File: rtl/complex_integer_divider_unit.sv
// Iterative radix-2 restoring divider for the complex-integer execute stage.
// Reserved at issue, cancelled on register-read flush, started in execute; the
// result is held until writeback acknowledges it, so only one div is in flight.
module complex_integer_divider_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 7,
  parameter int unsigned PREG_WIDTH = 7
) (
  input logic                          clk,
  input logic                          rst,
  complex_integer_divider_unit_if.slave bus
);
  localparam int unsigned CntWidth = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StFree, StReserved, StBusy, StDone} state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [DATA_WIDTH-1:0] rem_q;     // partial remainder, always < divisor
  logic [DATA_WIDTH-1:0] quo_q;     // dividend bits shift out, quotient bits shift in
  logic [DATA_WIDTH-1:0] dvs_q;     // divisor magnitude
  logic                  is_rem_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [PREG_WIDTH-1:0] dst_q;

  // Operand decode at start: magnitudes, sign flags and the one-cycle special cases.
  logic                  is_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic                  div_zero;
  logic                  overflow;

  always_comb begin
    is_signed = ~bus.op[0];
    a_neg     = is_signed & bus.dividend[DATA_WIDTH-1];
    b_neg     = is_signed & bus.divisor[DATA_WIDTH-1];
    a_mag     = a_neg ? -bus.dividend : bus.dividend;
    b_mag     = b_neg ? -bus.divisor : bus.divisor;
    div_zero  = (bus.divisor == '0);
    overflow  = is_signed & (bus.dividend == MinNeg) & (bus.divisor == '1);
  end

  // One restoring step: shift in next dividend MSB, subtract divisor if it fits.
  logic [DATA_WIDTH:0] rem_shift;
  logic [DATA_WIDTH:0] rem_diff;
  logic                fits;

  always_comb begin
    rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    fits      = ~rem_diff[DATA_WIDTH];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFree;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      tag_q     <= '0;
      dst_q     <= '0;
    end else begin
      unique case (state_q)
        StFree: begin
          if (bus.reserve) state_q <= StReserved;
        end
        StReserved: begin
          if (bus.cancel || bus.flush_inflight) begin
            state_q <= StFree;
          end else if (bus.start) begin
            is_rem_q <= bus.op[1];
            tag_q    <= bus.tag_in;
            dst_q    <= bus.dst_in;
            dvs_q    <= b_mag;
            if (div_zero) begin
              // Results are final: no sign fix applies.
              quo_q     <= '1;
              rem_q     <= bus.dividend;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= StDone;
            end else if (overflow) begin
              quo_q     <= MinNeg;
              rem_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= StDone;
            end else begin
              quo_q     <= a_mag;
              rem_q     <= '0;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              cnt_q     <= CntWidth'(DATA_WIDTH - 1);
              state_q   <= StBusy;
            end
          end
        end
        StBusy: begin
          if (bus.flush_inflight) begin
            state_q <= StFree;
          end else begin
            rem_q <= fits ? rem_diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
            quo_q <= {quo_q[DATA_WIDTH-2:0], fits};
            if (cnt_q == '0) state_q <= StDone;
            else             cnt_q   <= cnt_q - CntWidth'(1);
          end
        end
        StDone: begin
          if (bus.flush_inflight) begin
            state_q <= StFree;
          end else if (bus.result_ack) begin
            state_q <= bus.reserve ? StReserved : StFree;
          end
        end
        default: state_q <= StFree;
      endcase
    end
  end

  // Output view: sign fix applied on the held magnitudes while in DONE.
  logic [DATA_WIDTH-1:0] sel_mag;
  logic                  sel_neg;

  always_comb begin
    sel_mag = is_rem_q ? rem_q : quo_q;
    sel_neg = is_rem_q ? neg_rem_q : neg_quo_q;
  end

  assign bus.result_valid = (state_q == StDone);
  assign bus.result       = (state_q == StDone) ? (sel_neg ? -sel_mag : sel_mag) : '0;
  assign bus.tag_out      = tag_q;
  assign bus.dst_out      = dst_q;
  assign bus.is_free      = (state_q == StFree) ||
                            ((state_q == StDone) && bus.result_ack && !bus.flush_inflight);

  // Issue queue must never reserve a unit that is not free.
  reserve_when_free_a : assert property (@(posedge clk) disable iff (!rst)
    bus.reserve |-> bus.is_free);

endmodule

// File: tb/tb_complex_integer_divider_unit.sv
// Directed bench: stimulus pushes expected results into a scoreboard queue; a
// monitor pops and compares on each rising result_valid.
module tb_complex_integer_divider_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 7;
  localparam int unsigned PW = 7;

  localparam logic [1:0] OpDiv  = 2'd0;
  localparam logic [1:0] OpDivu = 2'd1;
  localparam logic [1:0] OpRem  = 2'd2;
  localparam logic [1:0] OpRemu = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  complex_integer_divider_unit_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .PREG_WIDTH(PW)) bus ();

  complex_integer_divider_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .PREG_WIDTH(PW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic [PW-1:0] dst;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison set per result presentation.
  logic prev_v = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && bus.result_valid === 1'b1 && !prev_v) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %h expected none", bus.result);
      end else begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("tag_out", 32'(bus.tag_out), 32'(e.tag));
        check("dst_out", 32'(bus.dst_out), 32'(e.dst));
      end
    end
    prev_v = (bus.result_valid === 1'b1);
  end

  // Reserve from FREE, then start next cycle; returns just after the start edge.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag, input logic [PW-1:0] dst,
                       input logic [DW-1:0] exp, input bit push);
    exp_t e;
    bus.reserve = 1'b1;
    tick();
    bus.reserve = 1'b0;
    check("is_free_reserved", 32'(bus.is_free), 32'd0);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.tag_in   = tag;
    bus.dst_in   = dst;
    if (push) begin
      e.res = exp;
      e.tag = tag;
      e.dst = dst;
      sb.push_back(e);
    end
    tick();
    bus.start = 1'b0;
  endtask

  // Counts edges after the start edge until result_valid.
  task automatic wait_valid(input int exp_lat, input string name);
    int lat = 0;
    while (bus.result_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic ack();
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check("is_free_after_ack", 32'(bus.is_free), 32'd1);
    check("valid_after_ack", 32'(bus.result_valid), 32'd0);
  endtask

  task automatic run(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [DW-1:0] exp, input int lat, input string name);
    issue(op, a, b, 7'h11, 7'h22, exp, 1'b1);
    wait_valid(lat, name);
    ack();
  endtask

  initial begin
    int vcnt;
    bus.reserve        = 1'b0;
    bus.cancel         = 1'b0;
    bus.start          = 1'b0;
    bus.op             = '0;
    bus.dividend       = '0;
    bus.divisor        = '0;
    bus.tag_in         = '0;
    bus.dst_in         = '0;
    bus.flush_inflight = 1'b0;
    bus.result_ack     = 1'b0;

    #12;
    check("rst_is_free", 32'(bus.is_free), 32'd1);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_tag", 32'(bus.tag_out), 32'd0);
    check("rst_dst", 32'(bus.dst_out), 32'd0);
    rst = 1'b1;
    tick();

    // Unsigned with tag/dst echo.
    issue(OpDivu, 32'd100, 32'd7, 7'h5A, 7'h33, 32'd14, 1'b1);
    wait_valid(32, "divu_100_7");
    ack();
    run(OpRemu, 32'd100, 32'd7, 32'd2, 32, "remu_100_7");

    // Signed cases and overflow.
    run(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, "div_m7_2");
    run(OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, "rem_m7_2");
    run(OpDiv, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32, "div_100_m7");
    run(OpRem, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32, "rem_m100_7");
    run(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
    run(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, "rem_ovf");

    // Divide by zero.
    run(OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, "divu_5_0");
    run(OpRem, 32'd5, 32'd0, 32'd5, 0, "rem_5_0");

    // Cancel beats start in RESERVED.
    bus.reserve = 1'b1;
    tick();
    bus.reserve  = 1'b0;
    bus.cancel   = 1'b1;
    bus.start    = 1'b1;
    bus.op       = OpDivu;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    tick();
    bus.cancel = 1'b0;
    bus.start  = 1'b0;
    check("cancel_is_free", 32'(bus.is_free), 32'd1);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.result_valid === 1'b1) vcnt++;
      tick();
    end
    check("cancel_no_valid", 32'(vcnt), 32'd0);

    // Flush during iteration 10.
    issue(OpDivu, 32'd1000, 32'd3, 7'h01, 7'h02, 32'd0, 1'b0);
    repeat (9) tick();
    check("busy_is_free", 32'(bus.is_free), 32'd0);
    bus.flush_inflight = 1'b1;
    tick();
    bus.flush_inflight = 1'b0;
    check("flush_busy_is_free", 32'(bus.is_free), 32'd1);
    check("flush_busy_valid", 32'(bus.result_valid), 32'd0);
    repeat (35) tick();

    // Flush has priority over ack in DONE.
    issue(OpDivu, 32'd9, 32'd3, 7'h0C, 7'h0D, 32'd3, 1'b1);
    wait_valid(32, "divu_9_3");
    bus.flush_inflight = 1'b1;
    bus.result_ack     = 1'b1;
    #1;
    check("flush_ack_is_free_comb", 32'(bus.is_free), 32'd0);
    tick();
    bus.flush_inflight = 1'b0;
    bus.result_ack     = 1'b0;
    check("flush_done_valid", 32'(bus.result_valid), 32'd0);
    check("flush_done_is_free", 32'(bus.is_free), 32'd1);

    // Back-to-back: ack with reserve goes straight to RESERVED.
    issue(OpDivu, 32'd1000, 32'd10, 7'h21, 7'h31, 32'd100, 1'b1);
    wait_valid(32, "divu_1000_10");
    bus.result_ack = 1'b1;
    bus.reserve    = 1'b1;
    #1;
    check("b2b_is_free_comb", 32'(bus.is_free), 32'd1);
    tick();
    bus.result_ack = 1'b0;
    bus.reserve    = 1'b0;
    check("b2b_valid", 32'(bus.result_valid), 32'd0);
    check("b2b_reserved", 32'(bus.is_free), 32'd0);
    bus.start    = 1'b1;
    bus.op       = OpDivu;
    bus.dividend = 32'hFFFF_FFFF;
    bus.divisor  = 32'h10;
    bus.tag_in   = 7'h22;
    bus.dst_in   = 7'h32;
    sb.push_back('{res: 32'h0FFF_FFFF, tag: 7'h22, dst: 7'h32});
    tick();
    bus.start = 1'b0;
    wait_valid(32, "b2b_second");
    ack();

    // Asynchronous reset mid-BUSY, checked before any clock edge.
    issue(OpDivu, 32'd77, 32'd5, 7'h55, 7'h2A, 32'd0, 1'b0);
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_is_free", 32'(bus.is_free), 32'd1);
    check("arst_valid", 32'(bus.result_valid), 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_tag", 32'(bus.tag_out), 32'd0);
    check("arst_dst", 32'(bus.dst_out), 32'd0);
    #1;
    rst = 1'b1;
    repeat (3) tick();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
